// File: rtl/trace_pkg.sv
// Shared record layout and defaults for the commit trace buffer.
package trace_pkg;

  localparam int DEFAULT_DEPTH = 8;
  localparam int SEQ_W         = 32;
  localparam int XLEN          = 32;
  localparam int RD_W          = 5;
  localparam int DROP_W        = 16;

  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic [XLEN-1:0]  pc;
    logic             regwrite;
    logic [RD_W-1:0]  rd;
    logic [XLEN-1:0]  wdata;
    logic             memwrite;
    logic [XLEN-1:0]  memaddr;
    logic [XLEN-1:0]  memwdata;
  } trace_rec_t;

  localparam int TRACE_W = $bits(trace_rec_t);

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with an array store and a registered head word;
// a push into an empty (or draining-to-empty) FIFO bypasses the array.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] head_reg;
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW-1:0]    rd_ptr_next;
  logic [CW-1:0]    count_reg;
  logic             push_eff;
  logic             pop_eff;
  logic             bypass;

  assign push_eff    = push && !flush;
  assign pop_eff     = pop && !flush;
  assign rd_ptr_next = rd_ptr_reg + AW'(pop_eff);
  // The new word becomes head when nothing older survives this edge.
  assign bypass      = push_eff && ((count_reg - CW'(pop_eff)) == '0);

  always_ff @(posedge clock) begin
    if (push_eff) begin
      mem[wr_ptr_reg] <= wdata;
    end
  end

  always_ff @(posedge clock) begin
    head_reg <= bypass ? wdata : mem[rd_ptr_next];
  end

  always_ff @(posedge clock) begin
    if (!reset_n || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_eff) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      rd_ptr_reg <= rd_ptr_next;
      case ({push_eff, pop_eff})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign rdata = head_reg;
  assign count = count_reg;

endmodule

// File: rtl/commit_trace_buffer.sv
// Buffers retired-instruction records for a trace consumer, tagging each
// with a commit sequence number so that dropped records show up as seq gaps.
module commit_trace_buffer
  import trace_pkg::*;
#(
  parameter int DEPTH        = DEFAULT_DEPTH,
  parameter int AFULL_MARGIN = 2
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     commit_valid,
  input  logic [XLEN-1:0]          c_pc,
  input  logic [XLEN-1:0]          c_wdata,
  input  logic [XLEN-1:0]          c_memaddr,
  input  logic [XLEN-1:0]          c_memwdata,
  input  logic                     c_regwrite,
  input  logic                     c_memwrite,
  input  logic [RD_W-1:0]          c_rd,
  input  logic                     flush,
  input  logic                     clear_overflow,
  output logic                     trace_valid,
  input  logic                     trace_ready,
  output logic [TRACE_W-1:0]       trace_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     almost_full,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_count
);

  localparam int LW = $clog2(DEPTH) + 1;

  trace_rec_t        rec_in;
  logic [TRACE_W-1:0] rec_out;
  logic [LW-1:0]     count;
  logic [SEQ_W-1:0]  seq_reg;
  logic              overflow_reg;
  logic [DROP_W-1:0] drop_count_reg;
  logic              full;
  logic              push;
  logic              pop;
  logic              drop;

  assign trace_valid = (count != '0);
  assign full        = (count == LW'(DEPTH));
  assign pop         = trace_valid && trace_ready && !flush;
  assign push        = commit_valid && (!full || pop) && !flush;
  assign drop        = commit_valid && full && !pop && !flush;

  always_comb begin
    rec_in.seq      = seq_reg;
    rec_in.pc       = c_pc;
    rec_in.regwrite = c_regwrite;
    rec_in.rd       = c_rd;
    rec_in.wdata    = c_wdata;
    rec_in.memwrite = c_memwrite;
    rec_in.memaddr  = c_memaddr;
    rec_in.memwdata = c_memwdata;
  end

  sync_fifo #(
    .WIDTH (TRACE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .flush   (flush),
    .push    (push),
    .pop     (pop),
    .wdata   (rec_in),
    .rdata   (rec_out),
    .count   (count)
  );

  // Counts every commit, stored or not, so seq gaps expose drops.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      seq_reg <= '0;
    end else if (commit_valid) begin
      seq_reg <= seq_reg + SEQ_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      overflow_reg   <= 1'b0;
      drop_count_reg <= '0;
    end else if (drop) begin
      overflow_reg <= 1'b1;
      if (clear_overflow) begin
        drop_count_reg <= DROP_W'(1);
      end else if (drop_count_reg != '1) begin
        drop_count_reg <= drop_count_reg + DROP_W'(1);
      end
    end else if (clear_overflow) begin
      overflow_reg   <= 1'b0;
      drop_count_reg <= '0;
    end
  end

  assign trace_data  = rec_out;
  assign level       = count;
  assign almost_full = (count >= LW'(DEPTH - AFULL_MARGIN));
  assign overflow    = overflow_reg;
  assign drop_count  = drop_count_reg;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Randomised scoreboard bench for commit_trace_buffer against a queue model.
module tb_commit_trace_buffer;

  localparam int DEPTH = 8;
  localparam int AFM   = 2;
  localparam int LW    = 4;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          commit_valid = 1'b0;
  logic [31:0]   c_pc = '0, c_wdata = '0, c_memaddr = '0, c_memwdata = '0;
  logic          c_regwrite = 1'b0, c_memwrite = 1'b0;
  logic [4:0]    c_rd = '0;
  logic          flush = 1'b0, clear_overflow = 1'b0;
  logic          trace_valid;
  logic          trace_ready = 1'b0;
  logic [166:0]  trace_data;
  logic [LW-1:0] level;
  logic          almost_full, overflow;
  logic [15:0]   drop_count;

  always #5 clock = ~clock;

  commit_trace_buffer #(.DEPTH(DEPTH), .AFULL_MARGIN(AFM)) dut (
    .clock(clock), .reset_n(reset_n), .commit_valid(commit_valid),
    .c_pc(c_pc), .c_wdata(c_wdata), .c_memaddr(c_memaddr), .c_memwdata(c_memwdata),
    .c_regwrite(c_regwrite), .c_memwrite(c_memwrite), .c_rd(c_rd),
    .flush(flush), .clear_overflow(clear_overflow),
    .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_data(trace_data),
    .level(level), .almost_full(almost_full), .overflow(overflow), .drop_count(drop_count)
  );

  typedef struct {
    bit chk;
    int lvl;
    bit af;
    bit ovf;
    int drops;
  } stat_t;

  int           compared = 0;
  int           mismatched = 0;
  logic [166:0] exp_q[$];
  logic [166:0] model_q[$];
  stat_t        stat_q[$];
  logic [31:0]  m_seq = '0;
  logic [31:0]  pc_ctr = '0;
  bit           m_ovf = 0;
  int           m_drops = 0;
  bit           m_known = 0;

  task automatic chk(input string name, input logic [166:0] act, input logic [166:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model predicts what the next edge does.
  task automatic step(input bit rst_n, input bit cv, input bit rdy, input bit fl, input bit clr);
    stat_t        s;
    logic [166:0] rec;
    bit           pop_m, full_m, drop_m;
    @(negedge clock);
    s.chk   = m_known;
    s.lvl   = model_q.size();
    s.af    = (model_q.size() >= DEPTH - AFM);
    s.ovf   = m_ovf;
    s.drops = m_drops;
    stat_q.push_back(s);

    reset_n        = rst_n;
    commit_valid   = cv;
    trace_ready    = rdy;
    flush          = fl;
    clear_overflow = clr;
    c_pc           = pc_ctr;
    c_wdata        = $urandom;
    c_memaddr      = $urandom;
    c_memwdata     = $urandom;
    c_regwrite     = 1'($urandom);
    c_memwrite     = 1'($urandom);
    c_rd           = 5'($urandom);
    rec = {m_seq, c_pc, c_regwrite, c_rd, c_wdata, c_memwrite, c_memaddr, c_memwdata};

    if (!rst_n) begin
      model_q.delete();
      m_seq   = '0;
      m_ovf   = 0;
      m_drops = 0;
      m_known = 1;
      pc_ctr  = '0;
    end else begin
      pop_m  = (model_q.size() > 0) && rdy && !fl;
      full_m = (model_q.size() == DEPTH);
      drop_m = cv && full_m && !pop_m && !fl;
      if (fl) begin
        model_q.delete();
      end else begin
        if (pop_m) exp_q.push_back(model_q.pop_front());
        if (cv && (!full_m || pop_m)) model_q.push_back(rec);
      end
      if (drop_m) begin
        m_ovf   = 1;
        m_drops = clr ? 1 : ((m_drops == 65535) ? 65535 : m_drops + 1);
      end else if (clr) begin
        m_ovf   = 0;
        m_drops = 0;
      end
      if (cv) begin
        m_seq  = m_seq + 1;
        pc_ctr = pc_ctr + 4;
      end
    end
  endtask

  // Monitor: checks status every cycle and pops the scoreboard on handshakes.
  initial begin
    stat_t s;
    forever begin
      @(negedge clock);
      #2;
      if (stat_q.size() > 0) begin
        s = stat_q.pop_front();
        if (s.chk) begin
          chk("level", 167'(level), 167'(s.lvl));
          chk("trace_valid", 167'(trace_valid), 167'(s.lvl != 0));
          chk("almost_full", 167'(almost_full), 167'(s.af));
          chk("overflow", 167'(overflow), 167'(s.ovf));
          chk("drop_count", 167'(drop_count), 167'(s.drops));
        end
      end
      if (reset_n === 1'b1 && flush === 1'b0 && trace_valid === 1'b1 && trace_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_pop: got %0h expected no record", trace_data);
        end else begin
          chk("trace_data", trace_data, exp_q.pop_front());
        end
      end
      if (exp_q.size() > 0) begin
        compared++;
        mismatched++;
        $display("FAIL missing_pop: got no handshake expected %0h", exp_q[0]);
        exp_q.delete();
      end
    end
  end

  initial begin
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);

    // three commits held, then drained in order
    repeat (3) step(1, 1, 0, 0, 0);
    repeat (4) step(1, 0, 1, 0, 0);

    // overfill by two: drops, almost_full, overflow
    repeat (10) step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    repeat (9) step(1, 0, 1, 0, 0);
    step(1, 0, 0, 0, 1);

    // push and pop together while full
    repeat (8) step(1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    repeat (9) step(1, 0, 1, 0, 0);

    // drop and clear in the same cycle
    repeat (9) step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    repeat (9) step(1, 0, 1, 0, 0);

    // sequence counter wrap
    step(1, 0, 0, 0, 0);
    force dut.seq_reg = 32'hFFFF_FFFE;
    step(1, 0, 0, 0, 0);
    release dut.seq_reg;
    m_seq = 32'hFFFF_FFFE;
    repeat (3) step(1, 1, 0, 0, 0);
    repeat (4) step(1, 0, 1, 0, 0);

    // flush with a simultaneous commit at level 5
    repeat (5) step(1, 1, 0, 0, 0);
    step(1, 1, 0, 1, 0);
    step(1, 1, 0, 0, 0);
    repeat (2) step(1, 0, 1, 0, 0);

    // reset mid-stream at level 4 with overflow set
    repeat (10) step(1, 1, 0, 0, 0);
    repeat (4) step(1, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    step(1, 1, 0, 0, 0);
    repeat (2) step(1, 0, 1, 0, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 999) != 0),
           ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 9) < 5),
           ($urandom_range(0, 99) < 2),
           ($urandom_range(0, 99) < 3));
    end

    repeat (DEPTH + 2) step(1, 0, 1, 0, 0);
    repeat (2) @(negedge clock);
    #4;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/commit_trace_buffer.md
COMMIT_TRACE_BUFFER -- requirements
Module: commit_trace_buffer

Interface
REQ-001 Parameter DEPTH, default 8, number of record entries; SHALL be a power of two and at least 4.
REQ-002 Parameter AFULL_MARGIN, default 2, free-entry threshold for almost_full.
REQ-003 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 commit_valid  input  1  one retired instruction is presented this cycle.
REQ-006 c_pc, c_wdata, c_memaddr, c_memwdata  input  32 each  committed PC, register write data, memory address, memory write data.
REQ-007 c_regwrite, c_memwrite  input  1 each  committed register-write and memory-write flags.
REQ-008 c_rd  input  5  committed destination register.
REQ-009 flush  input  1  discard all buffered records.
REQ-010 clear_overflow  input  1  clear overflow and drop_count.
REQ-011 trace_valid  output  1  head record available.
REQ-012 trace_ready  input  1  consumer accepts head record.
REQ-013 trace_data  output  167  packed record {seq[31:0], pc, regwrite, rd, wdata, memwrite, memaddr, memwdata}, MSB first.
REQ-014 level  output  $clog2(DEPTH)+1  number of occupied entries.
REQ-015 almost_full  output  1  level >= DEPTH-AFULL_MARGIN.
REQ-016 overflow  output  1  sticky: at least one record dropped.
REQ-017 drop_count  output  16  number of dropped records, saturating.

Function
REQ-018 Push SHALL occur when commit_valid=1 and (level<DEPTH or a pop occurs in the same cycle).
REQ-019 Pop SHALL occur when trace_valid=1 and trace_ready=1.
REQ-020 Record pushed at edge N SHALL appear on trace_data with trace_valid=1 after edge N, never combinationally in the push cycle (no fall-through).
REQ-021 trace_data SHALL remain stable while trace_valid=1 and trace_ready=0.
REQ-022 Simultaneous push and pop SHALL leave level unchanged, including at level=DEPTH and level=1.
REQ-023 A 32-bit sequence counter SHALL increment by 1 on every cycle with commit_valid=1, whether or not the record is stored, and wrap from 0xFFFFFFFF to 0.
REQ-024 Each stored record SHALL carry the counter value before that increment, so that gaps in seq identify drops.
REQ-025 commit_valid=1 with level=DEPTH and no pop SHALL drop the record, set overflow, and increment drop_count, which saturates at 0xFFFF.
REQ-026 Read and write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH.
REQ-027 flush=1 SHALL empty the buffer at the next edge (level=0, trace_valid=0) and SHALL ignore any push or pop in that cycle; the sequence counter, overflow and drop_count are unaffected.
REQ-028 clear_overflow=1 SHALL zero overflow and drop_count at the next edge; a drop in the same cycle SHALL take priority (overflow=1, drop_count=1).
REQ-029 almost_full and level SHALL be registered-state-derived; trace_valid SHALL equal (level!=0).

Reset
REQ-030 reset_n=0 at an edge SHALL set level=0, trace_valid=0, almost_full=0, overflow=0, drop_count=0, the sequence counter=0 and both pointers=0; reset SHALL take priority over all other inputs.
REQ-031 Entry storage need not be reset; trace_data is don't-care while trace_valid=0.

Structure
REQ-032 The record struct type (167 bits), its field widths, and the default DEPTH shall live in the shared package trace_pkg.
REQ-033 Storage SHALL be a single sub-module sync_fifo (parameterised width/depth, with count output); sequence counter, drop logic and status flags SHALL live in commit_trace_buffer.

Verification
REQ-034 After reset, push 3 commits (pc=0x0,0x4,0x8) with trace_ready=0 -> level=3; then trace_ready=1 yields seq 0,1,2 in order, one per cycle.
REQ-035 With DEPTH=8, push 10 commits with trace_ready=0 -> level=8, almost_full=1 from level 6, overflow=1, drop_count=2; drained seq values 0..7.
REQ-036 At level=8, set commit_valid=1 and trace_ready=1 together -> level stays 8, no drop, new record has seq=8.
REQ-037 Preload sequence counter to 0xFFFFFFFE via 3 commits after forcing -> stored seq 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
REQ-038 flush and commit_valid in the same cycle at level=5 -> level=0 next cycle; the following commit carries a seq one greater than the flushed one.
REQ-039 reset_n=0 mid-stream at level=4 with overflow=1 -> all outputs per REQ-030 on the following cycle; first post-reset commit has seq=0.
